// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the IF/MEM memory port arbiter.
`timescale 1ns/1ps
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        D_WAIT = 2'd1,
        I_WAIT = 2'd2,
        ERR    = 2'd3
    } arb_state_t;

    typedef logic [1:0] size_t;

    localparam size_t SZ_BYTE = 2'b00;
    localparam size_t SZ_HALF = 2'b01;
    localparam size_t SZ_WORD = 2'b10;

    localparam int DEFAULT_TIMEOUT = 16;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Valid/ready request bus between the arbiter (master) and the unified memory (slave).
`timescale 1ns/1ps
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    import mem_port_arbiter_pkg::*;

    logic              m_valid;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    size_t             m_size;
    logic              m_ready;
    logic [DATA_W-1:0] m_rdata;

    modport master (
        output m_valid, m_we, m_addr, m_wdata, m_size,
        input  m_ready, m_rdata
    );

    modport slave (
        input  m_valid, m_we, m_addr, m_wdata, m_size,
        output m_ready, m_rdata
    );

endinterface

// File: rtl/mem_port_arbiter_wait_timer.sv
// Loadable up-counter with clear/enable and a terminal-count flag against a runtime limit.
`timescale 1ns/1ps
module wait_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic [WIDTH-1:0] limit,
    output logic             tc
);

    logic [WIDTH-1:0] count_reg;

    // Clear wins over load, load wins over count.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (en) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign tc = (count_reg == limit);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between IF fetch and MEM load/store; data has priority, stalls freeze the pipe.
`timescale 1ns/1ps
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    input  logic              d_rd,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  size_t             d_size,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    mem_port_arbiter_if.master mem,
    output logic              stall_pipe,
    output logic              stall_fetch,
    output logic              bus_err
);

    localparam int               CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

    arb_state_t        state_reg;
    logic              m_valid_reg;
    logic              m_we_reg;
    logic [ADDR_W-1:0] m_addr_reg;
    logic [DATA_W-1:0] m_wdata_reg;
    size_t             m_size_reg;
    logic              if_done_reg;
    logic              d_done_reg;
    logic [DATA_W-1:0] if_rdata_reg;
    logic [DATA_W-1:0] d_rdata_reg;
    logic              discard_reg;
    logic              bus_err_reg;

    logic              issue;
    logic              timer_tc;

    // The done-pulse cycle is the mandatory gap: the requester still shows the
    // request it just completed, so nothing may be issued then.
    assign issue = (state_reg == IDLE) && !if_done_reg && !d_done_reg
                   && (d_rd || d_wr || if_req);

    wait_timer #(.WIDTH(CNT_W)) u_wait_timer (
        .clk      (clk),
        .rst      (rst),
        .clr      (issue),
        .load     (1'b0),
        .load_val ('0),
        .en       (m_valid_reg && !mem.m_ready),
        .limit    (LIMIT),
        .tc       (timer_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            m_valid_reg  <= 1'b0;
            m_we_reg     <= 1'b0;
            m_addr_reg   <= '0;
            m_wdata_reg  <= '0;
            m_size_reg   <= SZ_BYTE;
            if_done_reg  <= 1'b0;
            d_done_reg   <= 1'b0;
            if_rdata_reg <= '0;
            d_rdata_reg  <= '0;
            discard_reg  <= 1'b0;
            bus_err_reg  <= 1'b0;
        end else begin
            if_done_reg <= 1'b0;
            d_done_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (issue) begin
                        m_valid_reg <= 1'b1;
                        if (d_rd || d_wr) begin
                            m_we_reg    <= d_wr;
                            m_addr_reg  <= d_addr;
                            m_wdata_reg <= d_wdata;
                            m_size_reg  <= d_size;
                            state_reg   <= D_WAIT;
                        end else begin
                            m_we_reg    <= 1'b0;
                            m_addr_reg  <= if_addr;
                            m_size_reg  <= SZ_WORD;
                            discard_reg <= 1'b0;
                            state_reg   <= I_WAIT;
                        end
                    end
                end
                D_WAIT: begin
                    if (mem.m_ready) begin
                        m_valid_reg <= 1'b0;
                        d_done_reg  <= 1'b1;
                        if (!m_we_reg) begin
                            d_rdata_reg <= mem.m_rdata;
                        end
                        state_reg <= IDLE;
                    end else if (timer_tc) begin
                        m_valid_reg <= 1'b0;
                        bus_err_reg <= 1'b1;
                        state_reg   <= ERR;
                    end
                end
                I_WAIT: begin
                    if (mem.m_ready) begin
                        m_valid_reg <= 1'b0;
                        discard_reg <= 1'b0;
                        // A flush arriving with the data still kills this fetch.
                        if (!(discard_reg || if_flush)) begin
                            if_done_reg  <= 1'b1;
                            if_rdata_reg <= mem.m_rdata;
                        end
                        state_reg <= IDLE;
                    end else begin
                        if (if_flush) begin
                            discard_reg <= 1'b1;
                        end
                        if (timer_tc) begin
                            m_valid_reg <= 1'b0;
                            bus_err_reg <= 1'b1;
                            state_reg   <= ERR;
                        end
                    end
                end
                ERR: begin
                    state_reg <= ERR;
                end
            endcase
        end
    end

    assign mem.m_valid = m_valid_reg;
    assign mem.m_we    = m_we_reg;
    assign mem.m_addr  = m_addr_reg;
    assign mem.m_wdata = m_wdata_reg;
    assign mem.m_size  = m_size_reg;

    assign if_done  = if_done_reg;
    assign if_rdata = if_rdata_reg;
    assign d_done   = d_done_reg;
    assign d_rdata  = d_rdata_reg;
    assign bus_err  = bus_err_reg;

    assign stall_pipe  = ((d_rd || d_wr) && !d_done_reg) || (state_reg == ERR);
    assign stall_fetch = stall_pipe || (if_req && !if_done_reg);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: transaction-level model checked every cycle plus literal pins.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int TO = 16;

    logic        clk, rst;
    logic        if_req, if_flush, d_rd, d_wr;
    logic [31:0] if_addr, d_addr, d_wdata, if_rdata, d_rdata;
    logic [1:0]  d_size;
    logic        if_done, d_done, stall_pipe, stall_fetch, bus_err;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) mem_bus ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_flush    (if_flush),
        .if_rdata    (if_rdata),
        .if_done     (if_done),
        .d_rd        (d_rd),
        .d_wr        (d_wr),
        .d_addr      (d_addr),
        .d_wdata     (d_wdata),
        .d_size      (d_size),
        .d_rdata     (d_rdata),
        .d_done      (d_done),
        .mem         (mem_bus),
        .stall_pipe  (stall_pipe),
        .stall_fetch (stall_fetch),
        .bus_err     (bus_err)
    );

    int checks = 0;
    int errors = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h40:  return 32'h00A0_0093;
            32'h80:  return 32'h0050_0113;
            32'h100: return 32'h1234_5678;
            default: return a ^ 32'hA5A5_0000;
        endcase
    endfunction

    // Memory responder: answers after ready_delay extra cycles of m_valid.
    int ready_delay = 0;
    bit hang = 1'b0;
    bit spurious = 1'b0;
    int vcyc = 0;
    initial begin
        mem_bus.m_ready = 1'b0;
        mem_bus.m_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            vcyc = (mem_bus.m_valid === 1'b1) ? vcyc + 1 : 0;
            mem_bus.m_rdata = (mem_bus.m_valid === 1'b1) ? mem_word(mem_bus.m_addr) : 32'h0BAD_F00D;
            if (hang)
                mem_bus.m_ready = 1'b0;
            else if (mem_bus.m_valid === 1'b1)
                mem_bus.m_ready = (vcyc > ready_delay);
            else
                mem_bus.m_ready = spurious;
        end
    end

    // Transaction model: one outstanding access, a done pulse the cycle after
    // the memory answers, no issue during a done pulse, error after TO waits.
    bit          md_busy, md_data, md_we, md_drop, md_err, md_ifd, md_dd, chk_en;
    int          md_wait;
    logic [31:0] md_addr, md_wdata, md_ifr, md_dr;
    logic [1:0]  md_size;
    initial begin
        bit gap;
        chk_en = 1'b0;
        forever begin
            @(posedge clk);
            if (rst) begin
                md_busy = 0; md_data = 0; md_we = 0; md_drop = 0; md_err = 0;
                md_ifd = 0; md_dd = 0; md_wait = 0;
                md_addr = 0; md_wdata = 0; md_ifr = 0; md_dr = 0; md_size = 0;
                chk_en = 1'b1;
            end else begin
                gap = md_ifd || md_dd;
                md_ifd = 0;
                md_dd = 0;
                if (md_err) begin
                    md_busy = 0;
                end else if (md_busy) begin
                    if (mem_bus.m_ready) begin
                        md_busy = 0;
                        if (md_data) begin
                            md_dd = 1;
                            if (!md_we) md_dr = mem_word(md_addr);
                        end else if (!(md_drop || if_flush)) begin
                            md_ifd = 1;
                            md_ifr = mem_word(md_addr);
                        end
                        md_drop = 0;
                    end else begin
                        if (!md_data && if_flush) md_drop = 1;
                        md_wait++;
                        if (md_wait == TO) begin
                            md_busy = 0;
                            md_err = 1;
                        end
                    end
                end else if (!gap && (d_rd || d_wr)) begin
                    md_busy = 1; md_data = 1; md_we = d_wr; md_addr = d_addr;
                    md_wdata = d_wdata; md_size = d_size; md_wait = 0;
                end else if (!gap && if_req) begin
                    md_busy = 1; md_data = 0; md_we = 0; md_addr = if_addr;
                    md_size = SZ_WORD; md_wait = 0; md_drop = 0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("m_valid", mem_bus.m_valid, md_busy);
                if (md_busy) begin
                    check("m_addr", mem_bus.m_addr, md_addr);
                    check("m_we", mem_bus.m_we, md_we);
                    check("m_size", mem_bus.m_size, md_size);
                    if (md_we) check("m_wdata", mem_bus.m_wdata, md_wdata);
                end
                check("if_done", if_done, md_ifd);
                check("d_done", d_done, md_dd);
                check("bus_err", bus_err, md_err);
                if (md_ifd) check("if_rdata", if_rdata, md_ifr);
                if (md_dd && !md_we) check("d_rdata", d_rdata, md_dr);
                check("stall_pipe", stall_pipe, ((d_rd || d_wr) && !md_dd) || md_err);
                check("stall_fetch", stall_fetch,
                      ((d_rd || d_wr) && !md_dd) || md_err || (if_req && !md_ifd));
                if (if_done) $display("txn fetch addr=0x%08h data=0x%08h t=%0t", md_addr, if_rdata, $time);
                if (d_done) $display("txn %s addr=0x%08h data=0x%08h t=%0t", md_we ? "store" : "load",
                                     md_addr, md_we ? md_wdata : d_rdata, $time);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        int stall_n, done_n, dcyc, a80;
        logic [31:0] ddat;

        rst = 1; if_req = 0; if_addr = 0; if_flush = 0;
        d_rd = 0; d_wr = 0; d_addr = 0; d_wdata = 0; d_size = 0;
        tick(); tick();
        #1;
        check("rst_m_valid", mem_bus.m_valid, 0);
        check("rst_m_addr", mem_bus.m_addr, 0);
        check("rst_m_size", mem_bus.m_size, 0);
        check("rst_bus_err", bus_err, 0);
        check("rst_dones", {if_done, d_done}, 0);
        rst = 0;
        tick();

        // Fetch with immediate ready: if_done on the third cycle.
        if_req = 1; if_addr = 32'h40;
        #1 check("f_stall_c1", stall_fetch, 1);
        tick(); #1;
        check("f_valid_c2", mem_bus.m_valid, 1);
        check("f_addr_c2", mem_bus.m_addr, 32'h40);
        check("f_we_c2", mem_bus.m_we, 0);
        tick(); #1;
        check("f_done_c3", if_done, 1);
        check("f_rdata_c3", if_rdata, 32'h00A0_0093);
        check("f_stall_c3", stall_fetch, 0);
        if_req = 0;
        tick(); #1 check("f_done_c4", if_done, 0);

        // Load and fetch together: the load goes first, the fetch after the gap.
        d_rd = 1; d_addr = 32'h100; d_size = SZ_WORD; if_req = 1; if_addr = 32'h44;
        #1 check("s_stall_c1", stall_pipe, 1);
        tick(); #1 check("s_addr_c2", mem_bus.m_addr, 32'h100);
        tick(); #1;
        check("s_ddone_c3", d_done, 1);
        check("s_drdata_c3", d_rdata, 32'h1234_5678);
        check("s_stallp_c3", stall_pipe, 0);
        check("s_valid_c3", mem_bus.m_valid, 0);
        d_rd = 0;
        tick(); #1 check("s_valid_c4", mem_bus.m_valid, 0);
        tick(); #1 check("s_faddr_c5", {mem_bus.m_valid, mem_bus.m_addr[30:0]}, {1'b1, 31'h44});
        tick(); #1;
        check("s_fdone_c6", if_done, 1);
        check("s_frdata_c6", if_rdata, 32'hA5A5_0044);
        if_req = 0;
        tick();

        // Byte store with ready delayed three cycles.
        ready_delay = 3;
        d_wr = 1; d_addr = 32'h204; d_wdata = 32'hDEAD_BEEF; d_size = SZ_BYTE;
        stall_n = 0; done_n = 0;
        for (int i = 1; i <= 7; i++) begin
            if (i > 1) tick();
            #1;
            if (stall_pipe) stall_n++;
            if (d_done) begin done_n++; d_wr = 0; end
            if (i == 2) check("st_we", {mem_bus.m_we, mem_bus.m_size}, 3'b100);
            if (i == 5) check("st_wdata", mem_bus.m_wdata, 32'hDEAD_BEEF);
        end
        check("st_stall_cycles", stall_n, 5);
        check("st_done_count", done_n, 1);

        // Flush while waiting: 0x40 fetch dropped, 0x80 fetched instead.
        tick();
        if_req = 1; if_addr = 32'h40;
        done_n = 0; dcyc = 0; a80 = 0; ddat = 0;
        for (int i = 1; i <= 12; i++) begin
            if (i > 1) tick();
            if (i == 3) begin if_flush = 1; if_addr = 32'h80; end
            if (i == 4) if_flush = 0;
            #1;
            if (mem_bus.m_valid && mem_bus.m_addr == 32'h80 && a80 == 0) a80 = i;
            if (if_done) begin done_n++; dcyc = i; ddat = if_rdata; if_req = 0; end
        end
        check("fl_done_count", done_n, 1);
        check("fl_done_cycle", dcyc, 11);
        check("fl_rdata", ddat, 32'h0050_0113);
        check("fl_refetch_cycle", a80, 7);
        ready_delay = 0;

        // Flush on the same cycle as m_ready.
        tick();
        if_req = 1; if_addr = 32'h40;
        tick();
        if_flush = 1; if_addr = 32'h80;
        tick();
        if_flush = 0;
        #1 check("fr_no_done", if_done, 0);
        tick(); #1 check("fr_addr", mem_bus.m_addr, 32'h80);
        tick(); #1;
        check("fr_done", if_done, 1);
        check("fr_rdata", if_rdata, 32'h0050_0113);
        if_req = 0;

        // m_ready while idle must change nothing.
        spurious = 1;
        done_n = 0;
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            if (if_done || d_done || mem_bus.m_valid) done_n++;
        end
        check("spurious_idle", done_n, 0);
        spurious = 0;

        // Timeout: sixteen unanswered cycles, then sticky error until reset.
        tick();
        hang = 1;
        d_rd = 1; d_addr = 32'h300; d_size = SZ_WORD;
        for (int i = 2; i <= 18; i++) begin
            tick(); #1;
            if (i == 17) check("to_c17", {bus_err, mem_bus.m_valid}, 2'b01);
            if (i == 18) check("to_c18", {bus_err, mem_bus.m_valid, stall_pipe}, 3'b101);
        end
        d_rd = 0;
        #1 check("to_err_stall", stall_pipe, 1);
        tick(); tick(); tick(); #1;
        check("to_sticky", {bus_err, stall_pipe, mem_bus.m_valid}, 3'b110);
        rst = 1;
        tick(); #1;
        check("to_rst_clear", {bus_err, stall_pipe, mem_bus.m_valid}, 3'b000);
        rst = 0; hang = 0;

        // Reset in the middle of a load.
        tick();
        ready_delay = 5;
        d_rd = 1; d_addr = 32'h108; d_size = SZ_HALF;
        tick(); #1 check("ra_valid", mem_bus.m_valid, 1);
        tick();
        rst = 1;
        tick(); #1;
        check("ra_dropped", {mem_bus.m_valid, d_done, stall_pipe}, 3'b001);
        d_rd = 0; rst = 0;
        #1 check("ra_stall_follow", stall_pipe, 0);
        done_n = 0;
        for (int i = 0; i < 4; i++) begin
            tick(); #1;
            if (d_done || mem_bus.m_valid) done_n++;
        end
        check("ra_no_done", done_n, 0);
        ready_delay = 0;

        // Normal load after the reset still works.
        d_rd = 1; d_addr = 32'h100; d_size = SZ_WORD;
        tick(); tick(); #1;
        check("rec_ddone", {d_done, d_rdata}, {1'b1, 32'h1234_5678});
        d_rd = 0;
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
